// File: rtl/tx_batch_player.sv
// Waveform capture buffer and repeating DAC-side player.
// Loads batches over AXI-stream, then replays them N times (or forever) through a 2-entry skid.
module tx_batch_player #(
  parameter int unsigned PARALLEL_SAMPLES = 8,
  parameter int unsigned SAMPLE_WIDTH     = 16,
  parameter int unsigned DEPTH            = 1024,
  parameter int unsigned REPEAT_WIDTH     = 16
) (
  input  logic                                     clk_i,
  input  logic                                     reset_ni,
  input  logic [PARALLEL_SAMPLES*SAMPLE_WIDTH-1:0] s_data_i,
  input  logic                                     s_valid_i,
  input  logic                                     s_last_i,
  output logic                                     s_ready_o,
  input  logic                                     start_i,
  input  logic                                     stop_i,
  input  logic                                     clear_i,
  input  logic [REPEAT_WIDTH-1:0]                  repeat_count_i,
  output logic [PARALLEL_SAMPLES*SAMPLE_WIDTH-1:0] m_data_o,
  output logic                                     m_valid_o,
  input  logic                                     m_ready_i,
  output logic [$clog2(DEPTH):0]                   length_o,
  output logic                                     busy_o,
  output logic                                     done_o
);

  localparam int unsigned DataW = PARALLEL_SAMPLES * SAMPLE_WIDTH;
  localparam int unsigned AddrW = $clog2(DEPTH);
  localparam int unsigned LenW  = AddrW + 1;
  localparam logic [LenW-1:0] FullLen = LenW'(DEPTH);

  typedef enum logic [1:0] {StIdle, StLoaded, StPlay, StDrain} state_e;

  state_e                  state_q, state_d;
  logic [AddrW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LenW-1:0]         length_q, length_d;
  logic [REPEAT_WIDTH-1:0] pass_q, pass_d, rep_q, rep_d;
  logic                    s_ready_q;
  logic                    finite_q, finite_d;
  logic                    done_q, done_d;
  logic                    wr_en, rd_en, rd_vld_q;
  logic                    push, pop, last_idx;
  logic [1:0]              occ_next;

  logic [DataW-1:0]        mem_q [DEPTH];
  logic [DataW-1:0]        rd_data_q;
  logic [DataW-1:0]        m_data_q, m_data_d, sk_data_q, sk_data_d;
  logic                    m_valid_q, m_valid_d, sk_valid_q, sk_valid_d;

  // s_ready_q is only ever high while the state register holds StIdle.
  assign wr_en    = s_valid_i && s_ready_q;
  assign push     = rd_vld_q;
  assign pop      = m_valid_q && m_ready_i;
  assign last_idx = ({1'b0, rd_ptr_q} == (length_q - 1'b1));
  // Skid occupancy after this edge; a read issued now lands one cycle later and must fit.
  assign occ_next = {1'b0, m_valid_q} + {1'b0, sk_valid_q} + {1'b0, push} - {1'b0, pop};

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    length_d = length_q;
    pass_d   = pass_q;
    rep_d    = rep_q;
    finite_d = finite_q;
    done_d   = 1'b0;
    rd_en    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (wr_en) begin
          wr_ptr_d = wr_ptr_q + 1'b1;
          length_d = length_q + 1'b1;
          if (s_last_i || (length_q == FullLen - 1'b1)) begin
            state_d = StLoaded;
          end
        end
      end
      StLoaded: begin
        if (clear_i) begin
          state_d  = StIdle;
          length_d = '0;
          wr_ptr_d = '0;
        end else if (start_i && !stop_i && (length_q != '0)) begin
          state_d  = StPlay;
          rep_d    = repeat_count_i;
          rd_ptr_d = '0;
          pass_d   = '0;
          finite_d = 1'b0;
        end
      end
      StPlay: begin
        if (stop_i) begin
          state_d = StDrain;
        end else if (occ_next <= 2'd1) begin
          rd_en = 1'b1;
          if (last_idx) begin
            rd_ptr_d = '0;
            pass_d   = pass_q + 1'b1;
            if ((rep_q != '0) && ((pass_q + 1'b1) == rep_q)) begin
              state_d  = StDrain;
              finite_d = 1'b1;
            end
          end else begin
            rd_ptr_d = rd_ptr_q + 1'b1;
          end
        end
      end
      StDrain: begin
        if (!m_valid_q && !sk_valid_q && !rd_vld_q) begin
          state_d = StLoaded;
          done_d  = finite_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    m_data_d   = m_data_q;
    m_valid_d  = m_valid_q;
    sk_data_d  = sk_data_q;
    sk_valid_d = sk_valid_q;
    if (pop) begin
      if (sk_valid_q) begin
        m_data_d   = sk_data_q;
        m_valid_d  = 1'b1;
        sk_valid_d = push;
        if (push) begin
          sk_data_d = rd_data_q;
        end
      end else begin
        m_valid_d = push;
        if (push) begin
          m_data_d = rd_data_q;
        end
      end
    end else if (!m_valid_q) begin
      m_valid_d = push;
      if (push) begin
        m_data_d = rd_data_q;
      end
    end else if (push) begin
      sk_valid_d = 1'b1;
      sk_data_d  = rd_data_q;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q    <= StIdle;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      length_q   <= '0;
      pass_q     <= '0;
      rep_q      <= '0;
      finite_q   <= 1'b0;
      done_q     <= 1'b0;
      s_ready_q  <= 1'b0;
      rd_vld_q   <= 1'b0;
      m_data_q   <= '0;
      m_valid_q  <= 1'b0;
      sk_data_q  <= '0;
      sk_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      length_q   <= length_d;
      pass_q     <= pass_d;
      rep_q      <= rep_d;
      finite_q   <= finite_d;
      done_q     <= done_d;
      s_ready_q  <= (state_d == StIdle);
      rd_vld_q   <= rd_en;
      m_data_q   <= m_data_d;
      m_valid_q  <= m_valid_d;
      sk_data_q  <= sk_data_d;
      sk_valid_q <= sk_valid_d;
    end
  end

  // Buffer RAM: no reset, contents are only observable below length_q.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= s_data_i;
    end
    if (rd_en) begin
      rd_data_q <= mem_q[rd_ptr_q];
    end
  end

  assign s_ready_o = s_ready_q;
  assign m_data_o  = m_data_q;
  assign m_valid_o = m_valid_q;
  assign length_o  = length_q;
  assign busy_o    = (state_q == StPlay) || (state_q == StDrain);
  assign done_o    = done_q;

endmodule

// File: tb/tb_tx_batch_player.sv
// Self-checking bench for tx_batch_player: load, finite/infinite playback, backpressure,
// stop, full-buffer load, clear and asynchronous reset.
module tb_tx_batch_player;
  localparam int PS    = 8;
  localparam int SW    = 16;
  localparam int DEPTH = 8;
  localparam int RW    = 16;
  localparam int DW    = PS * SW;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic [DW-1:0] s_data = '0;
  logic          s_valid = 1'b0, s_last = 1'b0, s_ready;
  logic          start = 1'b0, stop = 1'b0, clear = 1'b0;
  logic [RW-1:0] repeat_count = '0;
  logic [DW-1:0] m_data;
  logic          m_valid, m_ready = 1'b0;
  logic [LW-1:0] length;
  logic          busy, done;

  int total = 0;
  int bad   = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] model [DEPTH];

  tx_batch_player #(
    .PARALLEL_SAMPLES(PS),
    .SAMPLE_WIDTH    (SW),
    .DEPTH           (DEPTH),
    .REPEAT_WIDTH    (RW)
  ) dut (
    .clk_i         (clk),
    .reset_ni      (reset_n),
    .s_data_i      (s_data),
    .s_valid_i     (s_valid),
    .s_last_i      (s_last),
    .s_ready_o     (s_ready),
    .start_i       (start),
    .stop_i        (stop),
    .clear_i       (clear),
    .repeat_count_i(repeat_count),
    .m_data_o      (m_data),
    .m_valid_o     (m_valid),
    .m_ready_i     (m_ready),
    .length_o      (length),
    .busy_o        (busy),
    .done_o        (done)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mk(input int base, input int b);
    logic [DW-1:0] r;
    for (int i = 0; i < PS; i++) r[i*SW +: SW] = SW'(base + b * PS + i);
    return r;
  endfunction

  task automatic load(input int n, input bit last, input int base, output int acc);
    int k = 0;
    for (int c = 0; c < n + 3 && k < n; c++) begin
      @(negedge clk);
      s_data  = mk(base, k);
      s_valid = 1'b1;
      s_last  = last && (k == n - 1);
      if (s_ready === 1'b1) begin
        if (k < DEPTH) model[k] = mk(base, k);
        k++;
      end
    end
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
    acc = k;
  endtask

  task automatic play(input int rep, input bit rnd, input int stop_after, input int len,
                      output int beats, output int dones, output int first_c, output int last_c);
    logic [DW-1:0] hold, e;
    bit held;
    int tail, n;
    exp_q.delete();
    n = (rep == 0) ? 24 : rep * len;
    for (int k = 0; k < n; k++) exp_q.push_back(model[k % len]);
    beats = 0; dones = 0; first_c = -1; last_c = -1; held = 0; hold = '0; tail = -1;
    @(negedge clk);
    repeat_count = RW'(rep);
    start = 1'b1;
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      start = 1'b0;
      stop  = 1'b0;
      if (held) begin
        total++;
        if (m_valid !== 1'b1 || m_data !== hold) begin
          bad++;
          $display("FAIL stall_hold: got valid=%b data=%h want valid=1 data=%h",
                   m_valid, m_data, hold);
        end
      end
      if (done === 1'b1) begin
        dones++;
        total++;
        if (busy !== 1'b0 || exp_q.size() != 0) begin
          bad++;
          $display("FAIL done_state: got busy=%b left=%0d want busy=0 left=0",
                   busy, exp_q.size());
        end
      end
      m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (m_valid === 1'b1 && m_ready) begin
        beats++;
        if (first_c < 0) first_c = c;
        last_c = c;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL beat_extra: got %h want no beat", m_data);
        end else begin
          e = exp_q.pop_front();
          if (m_data !== e) begin
            bad++;
            $display("FAIL beat_data[%0d]: got %h want %h", beats - 1, m_data, e);
          end
        end
        if (stop_after > 0 && beats == stop_after) stop = 1'b1;
      end
      held = (m_valid === 1'b1) && !m_ready;
      hold = m_data;
      if (tail < 0 && ((stop_after == 0 && dones > 0) ||
                       (stop_after > 0 && beats >= stop_after && busy === 1'b0 && !stop)))
        tail = c + 3;
      if (c == tail) break;
    end
    m_ready = 1'b0;
    if (tail < 0) begin
      total++;
      bad++;
      $display("FAIL play_timeout: got beats=%0d dones=%0d want completion", beats, dones);
    end
  endtask

  task automatic test_reset();
    #1 reset_n = 1'b0;
    #1;
    total++;
    if ({s_ready, m_valid, busy, done} !== 4'b0) begin
      bad++;
      $display("FAIL reset_flags: got rdy=%b vld=%b busy=%b done=%b want 0000",
               s_ready, m_valid, busy, done);
    end
    repeat (2) @(negedge clk);
    total++;
    if (length !== '0 || m_data !== '0 || s_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_values: got len=%0d data=%h rdy=%b want 0 0 0", length, m_data, s_ready);
    end
    reset_n = 1'b1;
    @(negedge clk);
    total++;
    if (s_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_release_ready: got %b want 1", s_ready);
    end
  endtask

  task automatic test_load4();
    int acc;
    load(4, 1'b1, 1, acc);
    total++;
    if (acc != 4 || length !== LW'(4) || s_ready !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL load4: got acc=%0d len=%0d rdy=%b busy=%b want 4 4 0 0",
               acc, length, s_ready, busy);
    end
  endtask

  task automatic test_play_full();
    int b, d, f, l;
    play(3, 1'b0, 0, 4, b, d, f, l);
    total++;
    if (b != 12 || d != 1 || f != 3 || l != 14) begin
      bad++;
      $display("FAIL play_full: got beats=%0d dones=%0d first=%0d last=%0d want 12 1 3 14",
               b, d, f, l);
    end
  endtask

  task automatic test_backpressure();
    int b, d, f, l;
    play(3, 1'b1, 0, 4, b, d, f, l);
    total++;
    if (b != 12 || d != 1) begin
      bad++;
      $display("FAIL backpressure: got beats=%0d dones=%0d want 12 1", b, d);
    end
  endtask

  task automatic test_stop();
    int b, d, f, l;
    play(0, 1'b0, 10, 4, b, d, f, l);
    total++;
    if (b < 10 || b > 12 || d != 0) begin
      bad++;
      $display("FAIL stop_drain: got beats=%0d dones=%0d want 10..12 0", b, d);
    end
    play(1, 1'b0, 0, 4, b, d, f, l);
    total++;
    if (b != 4 || d != 1 || f != 3) begin
      bad++;
      $display("FAIL restart: got beats=%0d dones=%0d first=%0d want 4 1 3", b, d, f);
    end
  endtask

  task automatic test_conflicts();
    @(negedge clk);
    repeat_count = RW'(1);
    start = 1'b1;
    stop  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || m_valid !== 1'b0) begin
      bad++;
      $display("FAIL start_stop: got busy=%b vld=%b want 0 0", busy, m_valid);
    end
    start = 1'b1;
    clear = 1'b1;
    @(negedge clk);
    start = 1'b0;
    clear = 1'b0;
    total++;
    if (busy !== 1'b0 || length !== '0 || s_ready !== 1'b1) begin
      bad++;
      $display("FAIL start_clear: got busy=%b len=%0d rdy=%b want 0 0 1", busy, length, s_ready);
    end
  endtask

  task automatic test_full_load();
    int acc, b, d, f, l;
    load(9, 1'b0, 'h100, acc);
    total++;
    if (acc != 8 || length !== LW'(8) || s_ready !== 1'b0) begin
      bad++;
      $display("FAIL full_load: got acc=%0d len=%0d rdy=%b want 8 8 0", acc, length, s_ready);
    end
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    total++;
    if (length !== '0 || s_ready !== 1'b1) begin
      bad++;
      $display("FAIL clear: got len=%0d rdy=%b want 0 1", length, s_ready);
    end
    load(2, 1'b1, 'h200, acc);
    total++;
    if (acc != 2 || length !== LW'(2)) begin
      bad++;
      $display("FAIL reload: got acc=%0d len=%0d want 2 2", acc, length);
    end
    play(1, 1'b0, 0, 2, b, d, f, l);
    total++;
    if (b != 2 || d != 1) begin
      bad++;
      $display("FAIL reload_play: got beats=%0d dones=%0d want 2 1", b, d);
    end
  endtask

  task automatic test_reset_mid();
    bit seen = 0;
    int bad_cnt = 0;
    @(negedge clk);
    repeat_count = '0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    m_ready = 1'b1;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      seen = (m_valid === 1'b1);
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL mid_wait_valid: got valid=%b want 1", m_valid);
    end
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    total++;
    if (m_valid !== 1'b0 || s_ready !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset: got vld=%b rdy=%b busy=%b want 0 0 0", m_valid, s_ready, busy);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    total++;
    if (s_ready !== 1'b1 || length !== '0) begin
      bad++;
      $display("FAIL mid_release: got rdy=%b len=%0d want 1 0", s_ready, length);
    end
    repeat_count = RW'(1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (m_valid !== 1'b0 || busy !== 1'b0 || s_ready !== 1'b1) bad_cnt++;
    end
    m_ready = 1'b0;
    total++;
    if (bad_cnt != 0) begin
      bad++;
      $display("FAIL idle_start_ignored: got %0d active cycles want 0", bad_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_load4();
    test_play_full();
    test_backpressure();
    test_stop();
    test_conflicts();
    test_full_load();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
